// File: rtl/axis_sa_seq.sv
// Tile sequencer for a systolic array: pairs x/k beats into the array and frames its results.
// Optional stall counters are built when AXIS_SA_SEQ_PERF_EN is defined.
module axis_sa_seq #(
    parameter int R    = 4,
    parameter int C    = 8,
    parameter int WX   = 4,
    parameter int WK   = 8,
    parameter int WY   = 16,
    parameter int WCNT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WCNT-1:0]   cfg_k,
    input  logic [WCNT-1:0]   cfg_tiles,
    input  logic              sx_valid,
    output logic              sx_ready,
    input  logic [R*WX-1:0]   sx_data,
    input  logic              sk_valid,
    output logic              sk_ready,
    input  logic [C*WK-1:0]   sk_data,
    output logic              sa_s_valid,
    input  logic              sa_s_ready,
    output logic              sa_s_last,
    output logic [R*WX-1:0]   sa_x_data,
    output logic [C*WK-1:0]   sa_k_data,
    input  logic              sa_m_valid,
    output logic              sa_m_ready,
    input  logic              sa_m_last,
    input  logic [R*WY-1:0]   sa_m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [R*WY-1:0]   m_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       perf_in_stall,
    output logic [31:0]       perf_out_stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [WCNT-1:0] C_LAST = WCNT'(C - 1);
    localparam logic [WCNT-1:0] ONE    = WCNT'(1);

    state_t          state;
    logic [WCNT-1:0] k_reg, t_reg;
    logic [WCNT-1:0] kcnt, tin_cnt, ocnt, tout_cnt;
    logic            run_q, ready_q, busy_q, done_q, err_q;

    logic accept, zero_cmd, in_fire, out_fire;
    logic k_last, tin_last, o_last_beat, tout_last, final_in, cmd_end;

    assign accept      = ready_q & cfg_valid;
    assign zero_cmd    = (cfg_k == '0) || (cfg_tiles == '0);
    assign k_last      = (kcnt == k_reg - ONE);
    assign tin_last    = (tin_cnt == t_reg - ONE);
    assign o_last_beat = (ocnt == C_LAST);
    assign tout_last   = (tout_cnt == t_reg - ONE);
    assign in_fire     = run_q & sx_valid & sk_valid & sa_s_ready;
    assign out_fire    = sa_m_valid & m_ready;
    assign final_in    = in_fire & k_last & tin_last;
    assign cmd_end     = out_fire & m_last;

    // x and k are only offered to the array as a pair, so neither stream can slip a beat.
    assign sa_s_valid = run_q & sx_valid & sk_valid;
    assign sx_ready   = run_q & sa_s_ready & sk_valid;
    assign sk_ready   = run_q & sa_s_ready & sx_valid;
    assign sa_s_last  = run_q & k_last;
    assign sa_x_data  = sx_data;
    assign sa_k_data  = sk_data;

    assign m_valid    = sa_m_valid;
    assign sa_m_ready = m_ready;
    assign m_data     = sa_m_data;
    assign m_last     = o_last_beat & tout_last;

    assign cfg_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            k_reg    <= '0;
            t_reg    <= '0;
            kcnt     <= '0;
            tin_cnt  <= '0;
            ocnt     <= '0;
            tout_cnt <= '0;
            run_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (accept) begin
                k_reg    <= cfg_k;
                t_reg    <= cfg_tiles;
                kcnt     <= '0;
                tin_cnt  <= '0;
                ocnt     <= '0;
                tout_cnt <= '0;
            end else begin
                if (in_fire) begin
                    if (k_last) begin
                        kcnt    <= '0;
                        tin_cnt <= tin_cnt + ONE;
                    end else begin
                        kcnt <= kcnt + ONE;
                    end
                end
                if (out_fire) begin
                    if (o_last_beat) begin
                        ocnt     <= '0;
                        tout_cnt <= tout_cnt + ONE;
                    end else begin
                        ocnt <= ocnt + ONE;
                    end
                end
            end

            // A framing fault seen on the accept cycle itself still wins over the clear.
            if (out_fire && ((sa_m_last != o_last_beat) || (state == IDLE)))
                err_q <= 1'b1;
            else if (accept)
                err_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (zero_cmd) begin
                            done_q <= 1'b1;
                        end else begin
                            state   <= RUN;
                            run_q   <= 1'b1;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (final_in) begin
                        run_q <= 1'b0;
                        if (cmd_end) begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cmd_end) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    run_q   <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXIS_SA_SEQ_PERF_EN
    logic [31:0] perf_in_q, perf_out_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_in_q  <= '0;
            perf_out_q <= '0;
        end else if (accept) begin
            perf_in_q  <= '0;
            perf_out_q <= '0;
        end else begin
            if (run_q && !(sa_s_valid && sa_s_ready) && (perf_in_q != '1))
                perf_in_q <= perf_in_q + 32'd1;
            if (sa_m_valid && !m_ready && (perf_out_q != '1))
                perf_out_q <= perf_out_q + 32'd1;
        end
    end

    assign perf_in_stall  = perf_in_q;
    assign perf_out_stall = perf_out_q;
`else
    assign perf_in_stall  = '0;
    assign perf_out_stall = '0;
`endif

endmodule

// File: tb/tb_axis_sa_seq.sv
// Self-checking bench for axis_sa_seq: a behavioural array model paces results behind each input tile.
// Expected stall counts follow AXIS_SA_SEQ_PERF_EN when it is defined for the build.
module tb_axis_sa_seq;

    localparam int C = 8;

`ifdef AXIS_SA_SEQ_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_valid, cfg_ready;
    logic [15:0] cfg_k, cfg_tiles;
    logic        sx_valid, sx_ready;
    logic [15:0] sx_data;
    logic        sk_valid, sk_ready;
    logic [63:0] sk_data;
    logic        sa_s_valid, sa_s_ready, sa_s_last;
    logic [15:0] sa_x_data;
    logic [63:0] sa_k_data;
    logic        sa_m_valid, sa_m_ready, sa_m_last;
    logic [63:0] sa_m_data;
    logic        m_valid, m_ready, m_last;
    logic [63:0] m_data;
    logic        busy, done, err;
    logic [31:0] perf_in_stall, perf_out_stall;

    int   n_vec = 0;
    int   n_err = 0;
    logic err_g = 1'b0;

    axis_sa_seq dut (
        .clk            (clk),
        .rstn           (rstn),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_k          (cfg_k),
        .cfg_tiles      (cfg_tiles),
        .sx_valid       (sx_valid),
        .sx_ready       (sx_ready),
        .sx_data        (sx_data),
        .sk_valid       (sk_valid),
        .sk_ready       (sk_ready),
        .sk_data        (sk_data),
        .sa_s_valid     (sa_s_valid),
        .sa_s_ready     (sa_s_ready),
        .sa_s_last      (sa_s_last),
        .sa_x_data      (sa_x_data),
        .sa_k_data      (sa_k_data),
        .sa_m_valid     (sa_m_valid),
        .sa_m_ready     (sa_m_ready),
        .sa_m_last      (sa_m_last),
        .sa_m_data      (sa_m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .m_data         (m_data),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .perf_in_stall  (perf_in_stall),
        .perf_out_stall (perf_out_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic quiet_inputs();
        cfg_valid  = 1'b0;
        sx_valid   = 1'b0;
        sk_valid   = 1'b0;
        sa_s_ready = 1'b0;
        sa_m_valid = 1'b0;
        sa_m_last  = 1'b0;
        m_ready    = 1'b1;
    endtask

    // Holds both streams valid while idle: nothing may be offered to the array.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sx_valid   = 1'b1;
            sk_valid   = 1'b1;
            sa_s_ready = 1'b1;
            #1;
            check("idle_sa_s_valid", sa_s_valid, 1'b0);
            check("idle_sx_ready", sx_ready, 1'b0);
            check("idle_busy", busy, 1'b0);
            check("idle_err", err, err_g);
        end
        sx_valid = 1'b0;
        sk_valid = 1'b0;
    endtask

    // One command: K*T paired input beats, then C result beats per finished tile from the array model.
    task automatic run_cmd(input int k, input int t, input int x_pct, input int k_pct,
                           input int rdy_pct, input int inj_beat, input int hold_n);
        int total_in, total_out, in_cnt, out_cnt, pend, held, x_seen, perf_in_e, perf_out_e;
        bit fin, done_seen, run, in_fire, out_fire;
        total_in  = k * t;
        total_out = (k == 0 || t == 0) ? 0 : C * t;
        in_cnt = 0; out_cnt = 0; pend = 0; held = 0; x_seen = 0;
        perf_in_e = 0; perf_out_e = 0;
        fin = (total_out == 0);
        done_seen = 1'b0;

        @(negedge clk);
        quiet_inputs();
        cfg_valid = 1'b1;
        cfg_k     = 16'(k);
        cfg_tiles = 16'(t);
        #1;
        check("cfg_ready_idle", cfg_ready, 1'b1);
        check("busy_before_accept", busy, 1'b0);
        check("err_before_accept", err, err_g);
        @(negedge clk);
        cfg_valid = 1'b0;
        err_g     = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            check("busy", busy, !fin);
            check("cfg_ready", cfg_ready, fin);
            check("done", done, fin && !done_seen);
            check("err", err, err_g);
            if (fin && done_seen) break;
            if (fin) done_seen = 1'b1;

            run        = (in_cnt < total_in);
            sx_valid   = ($urandom_range(99) < x_pct);
            sk_valid   = ($urandom_range(99) < k_pct);
            sx_data    = 16'($urandom());
            sk_data    = {$urandom(), $urandom()};
            sa_s_ready = ($urandom_range(99) < rdy_pct);
            sa_m_valid = (pend > 0);
            sa_m_data  = {$urandom(), $urandom()};
            sa_m_last  = ((out_cnt % C) == C - 1) || (out_cnt == inj_beat);
            if (sa_m_valid && held < hold_n) begin
                m_ready = 1'b0;
                held++;
            end else begin
                m_ready = ($urandom_range(99) < rdy_pct);
            end
            #1;

            check("sa_s_valid", sa_s_valid, run && sx_valid && sk_valid);
            check("sx_ready", sx_ready, run && sa_s_ready && sk_valid);
            check("sk_ready", sk_ready, run && sa_s_ready && sx_valid);
            check("xk_paired", sx_valid && sx_ready, sk_valid && sk_ready);
            check("sa_x_data", sa_x_data, sx_data);
            check("sa_k_data", sa_k_data, sk_data);
            check("m_valid", m_valid, sa_m_valid);
            check("sa_m_ready", sa_m_ready, m_ready);
            check("m_data", m_data, sa_m_data);

            if (sx_valid && sx_ready) x_seen++;
            in_fire = run && sx_valid && sk_valid && sa_s_ready;
            if (in_fire) begin
                check("sa_s_last", sa_s_last, ((in_cnt + 1) % k) == 0);
                in_cnt++;
                if ((in_cnt % k) == 0) pend += C;
            end else if (run) begin
                perf_in_e++;
            end

            out_fire = sa_m_valid && m_ready;
            if (sa_m_valid && !m_ready) perf_out_e++;
            if (out_fire) begin
                check("m_last", m_last, out_cnt == total_out - 1);
                if (out_cnt == inj_beat) err_g = 1'b1;
                if (out_cnt == total_out - 1) fin = 1'b1;
                out_cnt++;
                pend--;
            end
            @(negedge clk);
        end

        check("cmd_completed", done_seen, 1'b1);
        check("x_transfers", x_seen, total_in);
        check("perf_in_stall", perf_in_stall, PERF_EN ? perf_in_e : 0);
        check("perf_out_stall", perf_out_stall, PERF_EN ? perf_out_e : 0);
        quiet_inputs();
    endtask

    initial begin
        rstn      = 1'b0;
        cfg_k     = '0;
        cfg_tiles = '0;
        sx_data   = '0;
        sk_data   = '0;
        sa_m_data = '0;
        quiet_inputs();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_sa_s_valid", sa_s_valid, 1'b0);
        check("rst_perf_in", perf_in_stall, 32'd0);
        check("rst_perf_out", perf_out_stall, 32'd0);
        rstn = 1'b1;
        idle(2);

        // K=3, T=2, everything flowing
        run_cmd(3, 2, 100, 100, 100, -1, 0);
        // zero-length commands complete without moving beats
        run_cmd(0, 5, 100, 100, 100, -1, 0);
        run_cmd(4, 0, 100, 100, 100, -1, 0);
        // k stream at 50%, x always valid
        run_cmd(4, 3, 100, 50, 100, -1, 0);
        // random backpressure on every interface
        run_cmd(5, 2, 70, 70, 60, -1, 0);
        run_cmd(1, 3, 80, 60, 70, -1, 0);

        // early sa_m_last on beat 5 of the first tile: err stays up until the next accept
        run_cmd(2, 2, 100, 100, 100, 4, 0);
        idle(3);
        run_cmd(2, 1, 100, 100, 100, -1, 0);

        // reset two beats into a K=3, T=2 command
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_k     = 16'd3;
        cfg_tiles = 16'd2;
        @(negedge clk);
        cfg_valid  = 1'b0;
        sx_valid   = 1'b1;
        sk_valid   = 1'b1;
        sa_s_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("busy_mid_run", busy, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_cfg_ready", cfg_ready, 1'b1);
        check("arst_sa_s_valid", sa_s_valid, 1'b0);
        check("arst_sx_ready", sx_ready, 1'b0);
        check("arst_sk_ready", sk_ready, 1'b0);
        check("arst_perf_in", perf_in_stall, 32'd0);
        sx_valid = 1'b0;
        sk_valid = 1'b0;
        @(negedge clk);
        rstn  = 1'b1;
        err_g = 1'b0;
        run_cmd(2, 1, 100, 100, 100, -1, 0);

        // ten consecutive output stalls
        run_cmd(1, 1, 100, 100, 100, -1, 10);
        check("perf_out_ten", perf_out_stall, PERF_EN ? 32'd10 : 32'd0);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_sa_seq.md
AXIS_SA_SEQ -- requirements
Module: axis_sa_seq

Interface
REQ-001 SHALL have parameters: R, default 4, array rows; C, default 8, array columns; WX, default 4, x element width; WK, default 8, k element width; WY, default 16, y element width; WCNT, default 16, counter width.
REQ-002 SHALL have ports (one clock; reset is asynchronous and active-low):
  clk  in  1  clock
  rstn  in  1  asynchronous active-low reset
  cfg_valid/cfg_ready  in/out  1  command handshake
  cfg_k  in  WCNT  beats per tile (K)
  cfg_tiles  in  WCNT  tiles per command
  sx_valid/sx_ready  in/out  1  x stream handshake
  sx_data  in  R*WX  x beat
  sk_valid/sk_ready  in/out  1  k stream handshake
  sk_data  in  C*WK  k beat
  sa_s_valid/sa_s_ready  out/in  1  to array input
  sa_s_last  out  1  last beat of tile
  sa_x_data  out  R*WX  x to array
  sa_k_data  out  C*WK  k to array
  sa_m_valid/sa_m_ready  in/out  1  from array output
  sa_m_last  in  1  array last
  sa_m_data  in  R*WY  array result beat
  m_valid/m_ready  out/in  1  result stream
  m_last  out  1  last beat of command
  m_data  out  R*WY  result beat
  busy  out  1  command in progress
  done  out  1  one-cycle completion pulse
  err  out  1  sticky framing error
  perf_in_stall  out  32  input stall count
  perf_out_stall  out  32  output stall count

Function
REQ-003 SHALL implement FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-004 IDLE: cfg_ready=1; on cfg_valid, SHALL latch cfg_k and cfg_tiles, clear counters and err, and go to RUN next cycle.
REQ-005 IDLE: if cfg_k==0 or cfg_tiles==0, SHALL accept, pulse done next cycle, and stay IDLE; no beats moved.
REQ-006 cfg_ready SHALL be 0 in RUN and DRAIN.
REQ-007 RUN: sa_s_valid = sx_valid & sk_valid; sx_ready = sa_s_ready & sk_valid; sk_ready = sa_s_ready & sx_valid; x and k transfer only together.
REQ-008 sa_x_data/sa_k_data SHALL be combinational pass-through of sx_data/sk_data; zero added latency.
REQ-009 Beat counter kcnt SHALL count input transfers 0..K-1, wrapping to 0; sa_s_last=1 when kcnt==K-1.
REQ-010 Tile-in counter SHALL increment on each last-beat transfer; transfer of last beat of tile T-1 SHALL move FSM to DRAIN.
REQ-011 In IDLE and DRAIN: sa_s_valid, sx_ready, sk_ready SHALL be 0.
REQ-012 Output path in all states: m_valid=sa_m_valid, sa_m_ready=m_ready, m_data=sa_m_data (combinational).
REQ-013 Output beat counter ocnt SHALL count transfers 0..C-1, wrapping; tile-out counter SHALL increment at ocnt==C-1.
REQ-014 m_last SHALL be 1 only when ocnt==C-1 and tile-out==T-1.
REQ-015 err SHALL set when an output transfer has sa_m_last != (ocnt==C-1), or an output transfer occurs in IDLE; it holds until the next accepted command.
REQ-016 DRAIN: transfer with m_last SHALL move FSM to IDLE and pulse done one cycle later. A completion on the same cycle as the final input beat SHALL go straight to IDLE.
REQ-017 busy SHALL be 1 in RUN and DRAIN, else 0.
REQ-018 All counters SHALL be WCNT bits; K and T up to 2^WCNT-1 supported with no overflow.

Reset
REQ-019 Asserting rstn low SHALL asynchronously force IDLE, clear all counters, and set done=0, err=0, busy=0. Handshake outputs SHALL follow REQ-011.
REQ-020 Reset mid-command SHALL abandon the command; the system resets the array with the same rstn.

Configuration
REQ-021 With AXIS_SA_SEQ_PERF_EN defined: perf_in_stall SHALL count RUN cycles with sa_s_valid=0 or sa_s_ready=0.
REQ-022 With AXIS_SA_SEQ_PERF_EN defined: perf_out_stall SHALL count cycles with m_valid=1 and m_ready=0.
REQ-023 With AXIS_SA_SEQ_PERF_EN defined: both counters SHALL clear on command accept, saturate at 2^32-1, and clear on reset.
REQ-024 Without AXIS_SA_SEQ_PERF_EN: both perf ports SHALL be tied 0 and no counter logic synthesised.

Verification
REQ-025 K=3, T=2, streams always valid, m_ready=1 -> sa_s_last on beats 3 and 6; 16 outputs (C=8); m_last only on beat 16; done pulses once; err=0.
REQ-026 cfg_k=0, T=5 -> cfg_ready seen, no sx/sk transfer, done pulses the cycle after accept, busy stays 0.
REQ-027 sk_valid toggled 50%, sx_valid=1 -> no x-only transfers; total x transfers = K*T = 12 for K=4, T=3.
REQ-028 sa_m_last forced high on output beat 5 of a tile (C=8) -> err=1 and held until next command accepted, then err=0.
REQ-029 rstn pulsed low mid-RUN after 2 beats -> IDLE immediately, busy=0, done=0; new K=2, T=1 command completes normally.
REQ-030 With AXIS_SA_SEQ_PERF_EN, m_ready=0 for 10 cycles while m_valid=1 -> perf_out_stall=10; without the macro -> 0.
